// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command link (transmitter and receiver sides).
package spi_cmd_pkg;

  localparam logic [7:0]  CMD_LOAD       = 8'h01;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned COUNT_BYTES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_STORE,
    ST_DONE
  } cmd_state_t;

endpackage

// File: rtl/byte_fifo.sv
// 8-bit synchronous FIFO; a push while full is dropped unless a pop frees the slot in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_in.sv
// Receive-side LOAD command parser: buffers SPI bytes, decodes the frame and
// writes each assembled 32-bit word into the destination region.
module cmd_in #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CMD_LOAD   = spi_cmd_pkg::CMD_LOAD
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              byte_valid,
  input  logic [7:0]        byte_recv,
  input  logic [ADDR_W-1:0] region_begin,
  input  logic [ADDR_W-1:0] region_end,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_done,
  output logic              busy,
  output logic              cmd_done,
  output logic              cmd_err
);

  import spi_cmd_pkg::*;

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  cmd_state_t        state, state_n;
  logic [IDX_W-1:0]  byte_idx, byte_idx_n;
  logic [23:0]       count, count_n;
  logic [23:0]       word, word_n;
  logic [31:0]       remaining, remaining_n;
  logic [31:0]       count_full;
  logic [31:0]       region_size;
  logic [ADDR_W-1:0] region_diff;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_data_n;
  logic              mem_w_en_n, cmd_err_n, cmd_done_n, busy_n;
  logic              fifo_pop, fifo_empty, fifo_full;
  logic [7:0]        fifo_dout;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_byte_fifo (
    .clk   (clk),
    .rst_L (rst_L),
    .push  (byte_valid),
    .din   (byte_recv),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Bytes arrive LSB first, so shifting right leaves byte 0 in the low lane.
  assign count_full  = {fifo_dout, count};
  assign region_diff = region_end - region_begin;
  assign region_size = 32'(region_diff);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= ST_IDLE;
      byte_idx  <= '0;
      count     <= '0;
      word      <= '0;
      remaining <= '0;
      mem_w_en  <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      byte_idx  <= byte_idx_n;
      count     <= count_n;
      word      <= word_n;
      remaining <= remaining_n;
      mem_w_en  <= mem_w_en_n;
      mem_addr  <= mem_addr_n;
      mem_data  <= mem_data_n;
      busy      <= busy_n;
      cmd_done  <= cmd_done_n;
      cmd_err   <= cmd_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    byte_idx_n  = byte_idx;
    count_n     = count;
    word_n      = word;
    remaining_n = remaining;
    mem_w_en_n  = mem_w_en;
    mem_addr_n  = mem_addr;
    mem_data_n  = mem_data;
    cmd_err_n   = cmd_err;
    fifo_pop    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_dout == CMD_LOAD) begin
            cmd_err_n  = 1'b0;
            byte_idx_n = '0;
            mem_addr_n = region_begin;
            state_n    = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          count_n    = count_full[31:8];
          byte_idx_n = byte_idx + 1'b1;
          if (byte_idx == IDX_W'(COUNT_BYTES - 1)) begin
            if (count_full == 32'd0) begin
              state_n = ST_DONE;
            end else if (count_full > region_size) begin
              cmd_err_n = 1'b1;
              state_n   = ST_IDLE;
            end else begin
              remaining_n = count_full;
              byte_idx_n  = '0;
              state_n     = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_n     = {fifo_dout, word[23:8]};
          byte_idx_n = byte_idx + 1'b1;
          if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
            mem_data_n = {fifo_dout, word};
            mem_w_en_n = 1'b1;
            byte_idx_n = '0;
            state_n    = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        if (mem_done && mem_w_en) begin
          mem_w_en_n  = 1'b0;
          mem_addr_n  = mem_addr + 1'b1;
          remaining_n = remaining - 32'd1;
          byte_idx_n  = '0;
          state_n     = (remaining == 32'd1) ? ST_DONE : ST_DATA;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Overflow: byte arrives with no room and no pop freeing a slot.
    if (byte_valid && fifo_full && !fifo_pop) cmd_err_n = 1'b1;

    cmd_done_n = (state_n == ST_DONE);
    busy_n     = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_cmd_in.sv
// Scoreboard bench for cmd_in: stimulus queues expected writes, a memory-side
// responder pops and compares them whenever a write request appears.
module tb_cmd_in;

  localparam int unsigned ADDR_W = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_L;
  logic              byte_valid;
  logic [7:0]        byte_recv;
  logic [ADDR_W-1:0] region_begin;
  logic [ADDR_W-1:0] region_end;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_done;
  logic              busy;
  logic              cmd_done;
  logic              cmd_err;

  wr_t exp_q[$];
  int  checks     = 0;
  int  errors     = 0;
  int  done_cnt   = 0;
  int  done_delay = 1;

  cmd_in #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .CMD_LOAD(8'h01)) dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .byte_valid   (byte_valid),
    .byte_recv    (byte_recv),
    .region_begin (region_begin),
    .region_end   (region_end),
    .mem_w_en     (mem_w_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_done     (mem_done),
    .busy         (busy),
    .cmd_done     (cmd_done),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_recv  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w_en"}, 32'(mem_w_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_data"}, mem_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(cmd_done), 32'd0);
    chk({tag, "_err"},  32'(cmd_err), 32'd0);
  endtask

  // Memory-side responder and write monitor.
  initial begin : responder
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic              stable;
    wr_t               e;
    mem_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_L === 1'b1 && mem_w_en === 1'b1) begin
        a = mem_addr;
        d = mem_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", a, d);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(a), 32'(e.addr));
          chk("wr_data", d, e.data);
        end
        stable = 1'b1;
        for (int k = 0; k < done_delay; k++) begin
          @(negedge clk);
          if (mem_w_en !== 1'b1 || mem_addr !== a || mem_data !== d) stable = 1'b0;
        end
        chk("wr_stable", 32'(stable), 32'd1);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("wr_release", 32'(mem_w_en), 32'd0);
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (cmd_done === 1'b1) done_cnt++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_L        = 1'b0;
    byte_valid   = 1'b0;
    byte_recv    = 8'h00;
    region_begin = '0;
    region_end   = '0;
    cycles(3);
    chk_reset_outputs("rst");
    rst_L = 1'b1;
    cycles(2);

    // Basic two-word frame
    region_begin = 16'h0010;
    region_end   = 16'h0020;
    done_delay   = 1;
    push_exp(16'h0010, 32'hDEADBEEF);
    push_exp(16'h0011, 32'h12345678);
    send_byte(8'h01);
    send4(8'h02, 8'h00, 8'h00, 8'h00);
    send4(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send4(8'h78, 8'h56, 8'h34, 8'h12);
    wait_done(1, "basic_done");
    cycles(1);
    chk("basic_busy", 32'(busy), 32'd0);
    chk("basic_err", 32'(cmd_err), 32'd0);
    chk("basic_sb", 32'(exp_q.size()), 32'd0);

    // Zero count
    send_byte(8'h01);
    send4(8'h00, 8'h00, 8'h00, 8'h00);
    wait_done(2, "zero_done");
    cycles(1);
    chk("zero_err", 32'(cmd_err), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_w_en", 32'(mem_w_en), 32'd0);

    // Oversize count, then a good frame clears the error
    region_begin = 16'h0010;
    region_end   = 16'h0012;
    send_byte(8'h01);
    send4(8'h03, 8'h00, 8'h00, 8'h00);
    cycles(15);
    chk("over_err", 32'(cmd_err), 32'd1);
    chk("over_busy", 32'(busy), 32'd0);
    chk("over_nodone", 32'(done_cnt), 32'd2);
    push_exp(16'h0010, 32'h11223344);
    send_byte(8'h01);
    send4(8'h01, 8'h00, 8'h00, 8'h00);
    send4(8'h44, 8'h33, 8'h22, 8'h11);
    wait_done(3, "recover_done");
    cycles(1);
    chk("recover_err", 32'(cmd_err), 32'd0);
    chk("recover_sb", 32'(exp_q.size()), 32'd0);

    // Backpressure: next word fills the FIFO exactly during a long STORE
    region_begin = 16'h0020;
    region_end   = 16'h0030;
    done_delay   = 10;
    push_exp(16'h0020, 32'h44332211);
    push_exp(16'h0021, 32'h88776655);
    send_byte(8'h01);
    send4(8'h02, 8'h00, 8'h00, 8'h00);
    send4(8'h11, 8'h22, 8'h33, 8'h44);
    send4(8'h55, 8'h66, 8'h77, 8'h88);
    wait_done(4, "bp_done");
    cycles(1);
    chk("bp_err", 32'(cmd_err), 32'd0);
    chk("bp_sb", 32'(exp_q.size()), 32'd0);

    // Overflow: a fifth byte during the stalled STORE is dropped
    push_exp(16'h0020, 32'hA4A3A2A1);
    push_exp(16'h0021, 32'hB4B3B2B1);
    send_byte(8'h01);
    send4(8'h02, 8'h00, 8'h00, 8'h00);
    send4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    send4(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    send_byte(8'hB5);
    wait_done(5, "ovf_done");
    cycles(1);
    chk("ovf_err", 32'(cmd_err), 32'd1);
    chk("ovf_sb", 32'(exp_q.size()), 32'd0);

    // Junk bytes ahead of the command are skipped
    region_begin = 16'h0040;
    region_end   = 16'h0050;
    done_delay   = 1;
    push_exp(16'h0040, 32'hA1B2C3D4);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h01);
    send4(8'h01, 8'h00, 8'h00, 8'h00);
    send4(8'hD4, 8'hC3, 8'hB2, 8'hA1);
    wait_done(6, "junk_done");
    cycles(1);
    chk("junk_err", 32'(cmd_err), 32'd0);
    chk("junk_sb", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a data word
    send_byte(8'h01);
    send4(8'h01, 8'h00, 8'h00, 8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    cycles(3);
    chk("prerst_busy", 32'(busy), 32'd1);
    chk("prerst_addr", 32'(mem_addr), 32'h0040);
    rst_L = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    cycles(2);
    rst_L = 1'b1;
    cycles(2);
    send_byte(8'h33);
    send_byte(8'h44);
    cycles(20);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_w_en", 32'(mem_w_en), 32'd0);
    chk("postrst_nodone", 32'(done_cnt), 32'd6);
    chk("postrst_sb", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
